spi_slave_pico: RTL and testbench

Memory-mapped SPI slave (mode 0: CPOL=0, CPHA=0) on the PicoRV32-style native memory bus. It is the peer of the SPI master peripheral: it receives bytes clocked in by an external master, and returns a CPU-preloaded byte on MISO. SPI pins are oversampled in the `clk` domain; no logic is clocked by `SPI_Clk`. It exposes a data register, a status register and an interrupt line to the SoC.

---
 rtl/spi_pico_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_pico.sv | 132 +++++++++++++
 tb/tb_spi_slave_pico.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pico_pkg.sv
// Shared definitions for the PicoRV32-bus SPI slave: register offsets,
// status bit positions and the chip-select state encoding.
package spi_pico_pkg;
  localparam logic [31:0] DATA_OFS = 32'd0;
  localparam logic [31:0] STAT_OFS = 32'd4;

  localparam int ST_RXV = 0;
  localparam int ST_TXF = 1;
  localparam int ST_OVR = 2;

  typedef enum logic {IDLE, ACTIVE} spi_slv_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus one delay stage that
// turns the synchronised level into single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;
endmodule

// File: rtl/spi_slave_pico.sv
// Mode-0 SPI slave with a memory-mapped data/status register pair on the
// PicoRV32 native bus. All SPI pins are oversampled in the clk domain.
module spi_slave_pico
  import spi_pico_pkg::*;
#(
  parameter logic [31:0] ADDR      = 32'hcaca_bec0,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [7:0]  wdata,
  input  logic        wen,
  input  logic        mem_valid,
  output logic        mem_port_ready,
  output logic [7:0]  rdata,
  output logic        rx_int,
  input  logic        SPI_Clk,
  input  logic        SPI_CS_n,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        SPI_MISO_oe
);
  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(resetn), .din(SPI_Clk),
    .level(sck_s), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(resetn), .din(SPI_CS_n),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(resetn), .din(SPI_MOSI),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  // Only edges of SCK/CS and the level of MOSI drive the datapath.
  logic unused_sync;
  assign unused_sync = &{1'b0, sck_s, cs_s, mosi_rise, mosi_fall};

  spi_slv_state_t state, state_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, rx_data, tx_shift, tx_buf, status;
  logic       rx_valid, tx_full, overrun;
  logic       active, bit_in, byte_done, tx_load;
  logic       sel_data, sel_stat, req, wr_data, rd_data, wr_stat;

  assign active    = (state == ACTIVE);
  assign bit_in    = active && sck_rise;
  assign byte_done = bit_in && (bit_cnt == 3'd7);
  assign tx_load   = cs_fall || byte_done;

  assign sel_data = (addr == ADDR + DATA_OFS);
  assign sel_stat = (addr == ADDR + STAT_OFS);
  assign req      = mem_valid && (sel_data || sel_stat) && !mem_port_ready;
  assign wr_data  = req && wen && sel_data;
  assign rd_data  = req && !wen && sel_data;
  assign wr_stat  = req && wen && sel_stat;

  always_comb begin
    status         = 8'h00;
    status[ST_RXV] = rx_valid;
    status[ST_TXF] = tx_full;
    status[ST_OVR] = overrun;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_port_ready <= 1'b0;
      rdata          <= 8'h00;
    end else begin
      mem_port_ready <= req;
      if (req && !wen) rdata <= sel_data ? rx_data : status;
    end
  end

  // A TX write coinciding with a reload lands in the buffer after the reload
  // consumed the old contents, so it survives for the next byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      tx_shift <= IDLE_BYTE;
      tx_buf   <= 8'h00;
      tx_full  <= 1'b0;
    end else begin
      if (cs_fall || cs_rise) bit_cnt <= 3'd0;
      else if (bit_in)        bit_cnt <= bit_cnt + 3'd1;

      if (bit_in) rx_shift <= {rx_shift[6:0], mosi_s};
      if (byte_done) rx_data <= {rx_shift[6:0], mosi_s};

      if (byte_done)    rx_valid <= 1'b1;
      else if (rd_data) rx_valid <= 1'b0;

      if (byte_done && rx_valid && !rd_data) overrun <= 1'b1;
      else if (wr_stat && wdata[ST_OVR])     overrun <= 1'b0;

      if (tx_load)
        tx_shift <= tx_full ? tx_buf : IDLE_BYTE;
      else if (active && sck_fall && (bit_cnt != 3'd0))
        tx_shift <= {tx_shift[6:0], 1'b0};

      if (wr_data)      tx_full <= 1'b1;
      else if (tx_load) tx_full <= 1'b0;
      if (wr_data) tx_buf <= wdata;
    end
  end

  assign rx_int      = rx_valid;
  assign SPI_MISO    = tx_shift[7];
  assign SPI_MISO_oe = active;
endmodule

// File: tb/tb_spi_slave_pico.sv
// Bench for spi_slave_pico: a mode-0 SPI master model and a CPU bus driver
// exercise the slave; expected bytes flow through scoreboard queues.
module tb_spi_slave_pico;
  localparam logic [31:0] A_DATA = 32'hcaca_bec0;
  localparam logic [31:0] A_STAT = 32'hcaca_bec4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        wen = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_port_ready;
  logic [7:0]  rdata;
  logic        rx_int;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] spi_q[$];

  spi_slave_pico dut (
    .clk(clk), .resetn(resetn), .addr(addr), .wdata(wdata), .wen(wen),
    .mem_valid(mem_valid), .mem_port_ready(mem_port_ready), .rdata(rdata),
    .rx_int(rx_int), .SPI_Clk(sck), .SPI_CS_n(cs_n), .SPI_MOSI(mosi),
    .SPI_MISO(miso), .SPI_MISO_oe(miso_oe));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic bus_access(input logic [31:0] a, input logic w,
                            input logic [7:0] d, output logic [7:0] q);
    int n;
    @(negedge clk);
    addr = a; wen = w; wdata = d; mem_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_port_ready && n < 8);
    checks++;
    if (mem_port_ready !== 1'b1) begin
      errors++;
      $display("FAIL bus_ack: ready=%b required 1 within 8 cycles", mem_port_ready);
    end
    q = rdata;
    mem_valid = 1'b0; wen = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
    logic [7:0] q;
    bus_access(a, 1'b1, d, q);
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [7:0] q);
    bus_access(a, 1'b0, 8'h00, q);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Master samples MISO just before each rising SCK, 4 clk per half period.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] q, e;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_port_ready, rdata, rx_int, miso, miso_oe} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rdata=%h int=%b miso=%b oe=%b required 0 00 0 1 0",
               mem_port_ready, rdata, rx_int, miso, miso_oe);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h00);
    cpu_read(A_STAT, q);
    e = exp_q.pop_front();
    checks++;
    if (q !== e) begin errors++; $display("FAIL reset_status: got %h required %h", q, e); end
  endtask

  task automatic test_basic();
    logic [7:0] q, e, rx;
    cpu_write(A_DATA, 8'hA5);
    spi_q.push_back(8'hA5);
    cs_low();
    checks++;
    if (miso_oe !== 1'b1) begin errors++; $display("FAIL basic_oe_active: got %b required 1", miso_oe); end
    spi_byte(8'h3C, 8, rx);
    cs_high();
    e = spi_q.pop_front();
    checks++;
    if (rx !== e) begin errors++; $display("FAIL basic_miso: got %h required %h", rx, e); end
    checks++;
    if ({rx_int, miso_oe} !== 2'b10) begin
      errors++; $display("FAIL basic_int_oe: int=%b oe=%b required 1 0", rx_int, miso_oe);
    end
    exp_q.push_back(8'h01); exp_q.push_back(8'h3C); exp_q.push_back(8'h00);
    cpu_read(A_STAT, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL basic_status_before: got %h required %h", q, e); end
    cpu_read(A_DATA, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL basic_data: got %h required %h", q, e); end
    cpu_read(A_STAT, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL basic_status_after: got %h required %h", q, e); end
  endtask

  task automatic test_empty_tx();
    logic [7:0] q, e, rx;
    spi_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    cs_low(); spi_byte(8'h81, 8, rx); cs_high();
    e = spi_q.pop_front(); checks++;
    if (rx !== e) begin errors++; $display("FAIL empty_miso: got %h required %h", rx, e); end
    cpu_read(A_DATA, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL empty_data: got %h required %h", q, e); end
  endtask

  task automatic test_overrun();
    logic [7:0] q, e, rx;
    cs_low(); spi_byte(8'h11, 8, rx); cs_high();
    cs_low(); spi_byte(8'h22, 8, rx); cs_high();
    exp_q.push_back(8'h05); exp_q.push_back(8'h22); exp_q.push_back(8'h00);
    cpu_read(A_STAT, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL overrun_status: got %h required %h", q, e); end
    cpu_read(A_DATA, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL overrun_data: got %h required %h", q, e); end
    cpu_write(A_STAT, 8'h04);
    cpu_read(A_STAT, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL overrun_cleared: got %h required %h", q, e); end
  endtask

  task automatic test_bus_held();
    int acks;
    @(negedge clk);
    addr = A_STAT + 32'd4; wen = 1'b0; mem_valid = 1'b1; acks = 0;
    repeat (6) begin @(negedge clk); if (mem_port_ready) acks++; end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL bad_addr_ack: got %0d acks required 0", acks); end
    addr = A_STAT; acks = 0;
    repeat (6) begin @(negedge clk); if (mem_port_ready) acks++; end
    mem_valid = 1'b0;
    checks++;
    if (acks !== 3) begin errors++; $display("FAIL held_req_acks: got %0d acks required 3", acks); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, e, rx;
    cpu_write(A_DATA, 8'hC1);
    spi_q.push_back(8'hC1); spi_q.push_back(8'hEF);
    exp_q.push_back(8'hBE); exp_q.push_back(8'h55);
    cs_low();
    fork
      spi_byte(8'hBE, 8, rx);
      begin repeat (20) @(negedge clk); cpu_write(A_DATA, 8'hEF); end
    join
    e = spi_q.pop_front(); checks++;
    if (rx !== e) begin errors++; $display("FAIL b2b_miso1: got %h required %h", rx, e); end
    cpu_read(A_DATA, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL b2b_data1: got %h required %h", q, e); end
    spi_byte(8'h55, 8, rx);
    cs_high();
    e = spi_q.pop_front(); checks++;
    if (rx !== e) begin errors++; $display("FAIL b2b_miso2: got %h required %h", rx, e); end
    cpu_read(A_DATA, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL b2b_data2: got %h required %h", q, e); end
  endtask

  task automatic test_cs_abort();
    logic [7:0] q, e, rx;
    cs_low(); spi_byte(8'hF3, 5, rx); cs_high();
    cs_low(); spi_byte(8'h5A, 8, rx); cs_high();
    exp_q.push_back(8'h01); exp_q.push_back(8'h5A);
    cpu_read(A_STAT, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL abort_status: got %h required %h", q, e); end
    cpu_read(A_DATA, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL abort_data: got %h required %h", q, e); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, e, rx;
    cs_low(); spi_byte(8'h77, 8, rx); cs_high();
    cpu_write(A_DATA, 8'h00);
    cs_low(); spi_byte(8'h12, 3, rx);
    @(negedge clk);
    #3;
    resetn = 1'b0; cs_n = 1'b1; sck = 1'b0;
    #1;
    checks++;
    if ({mem_port_ready, rdata, rx_int, miso, miso_oe} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midreset_outputs: ready=%b rdata=%h int=%b miso=%b oe=%b required 0 00 0 1 0",
               mem_port_ready, rdata, rx_int, miso, miso_oe);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    spi_q.push_back(8'hFF);
    exp_q.push_back(8'h96); exp_q.push_back(8'h00);
    cs_low(); spi_byte(8'h96, 8, rx); cs_high();
    e = spi_q.pop_front(); checks++;
    if (rx !== e) begin errors++; $display("FAIL midreset_miso: got %h required %h", rx, e); end
    cpu_read(A_DATA, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL midreset_data: got %h required %h", q, e); end
    cpu_read(A_STAT, q); e = exp_q.pop_front(); checks++;
    if (q !== e) begin errors++; $display("FAIL midreset_status: got %h required %h", q, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_tx();
    test_overrun();
    test_bus_held();
    test_back_to_back();
    test_cs_abort();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || spi_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", exp_q.size(), spi_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
